// File: rtl/stage4_inst_queue.sv
// Decoded-instruction FIFO between decode and execute; wrap-bit pointers, sticky overflow.
// Optional combinational empty-queue bypass enabled by INST_QUEUE_BYPASS_EN.
module stage4_inst_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 128
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     queue_wen,
  input  logic [DATA_WIDTH-1:0]    enq_data,
  input  logic [31:0]              enq_pc,
  input  logic                     deq_ready,
  input  logic                     stall_queue,
  input  logic                     flush_queue,
  output logic                     deq_valid,
  output logic [DATA_WIDTH-1:0]    deq_data,
  output logic [31:0]              deq_pc,
  output logic                     is_queue_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [31:0]           r_mem_pc   [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_bypass;
  logic                  w_deq_fire;
  logic                  w_enq_fire;
  logic                  w_wr;
  logic                  w_rd;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

`ifdef INST_QUEUE_BYPASS_EN
  // Empty queue forwards the incoming bundle straight to the head.
  assign w_bypass  = w_empty & queue_wen & ~flush_queue;
  assign deq_valid = ~w_empty | w_bypass;
  assign deq_data  = w_bypass ? enq_data : r_mem_data[r_rptr[AW-1:0]];
  assign deq_pc    = w_bypass ? enq_pc   : r_mem_pc[r_rptr[AW-1:0]];
`else
  assign w_bypass  = 1'b0;
  assign deq_valid = ~w_empty;
  assign deq_data  = r_mem_data[r_rptr[AW-1:0]];
  assign deq_pc    = r_mem_pc[r_rptr[AW-1:0]];
`endif

  assign w_deq_fire = deq_valid & deq_ready & ~stall_queue;
  assign w_enq_fire = queue_wen & ~flush_queue & (~w_full | w_deq_fire);

  // A bundle consumed through the bypass never touches storage or pointers.
  assign w_wr = w_enq_fire & ~(w_bypass & w_deq_fire);
  assign w_rd = w_deq_fire & ~w_empty;

  assign is_queue_full = w_full;
  assign count         = r_wptr - r_rptr;
  assign overflow      = r_overflow;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else if (flush_queue) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
      if (queue_wen & ~w_enq_fire) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem_data[r_wptr[AW-1:0]] <= enq_data;
      r_mem_pc[r_wptr[AW-1:0]]   <= enq_pc;
    end
  end

endmodule

// File: tb/tb_stage4_inst_queue.sv
// Bench for stage4_inst_queue: vector table for status outputs, PC/data scoreboard for ordering.
module tb_stage4_inst_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 128;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            queue_wen;
  logic [DW-1:0]   enq_data;
  logic [31:0]     enq_pc;
  logic            deq_ready;
  logic            stall_queue;
  logic            flush_queue;
  logic            deq_valid;
  logic [DW-1:0]   deq_data;
  logic [31:0]     deq_pc;
  logic            is_queue_full;
  logic [2:0]      count;
  logic            overflow;

  stage4_inst_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .nRST(nRST), .queue_wen(queue_wen), .enq_data(enq_data), .enq_pc(enq_pc),
    .deq_ready(deq_ready), .stall_queue(stall_queue), .flush_queue(flush_queue),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_pc(deq_pc),
    .is_queue_full(is_queue_full), .count(count), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic        wen;
    logic [31:0] pc;
    logic        rdy;
    logic        stl;
    logic        fl;
    int          exp_cnt;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] sb_pc[$];
  logic        m_ovf;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [DW-1:0] mk_data(input logic [31:0] pc);
    return {pc, ~pc, pc + 32'h1357_9bdf, pc ^ 32'hA5A5_5A5A};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check head against scoreboard, update model, check status after edge.
  task automatic step(input logic rst_n, input logic wen, input logic [31:0] pc,
                      input logic rdy, input logic stl, input logic fl);
    logic        ev, fire, acc, byp;
    logic [31:0] epc;
    @(negedge CLK);
    nRST = rst_n; queue_wen = wen; enq_pc = pc; enq_data = mk_data(pc);
    deq_ready = rdy; stall_queue = stl; flush_queue = fl;
    #1;
    byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    byp = (sb_pc.size() == 0) && wen && !fl;
`endif
    ev  = (sb_pc.size() != 0) || byp;
    epc = (sb_pc.size() != 0) ? sb_pc[0] : pc;
    check("deq_valid", {127'b0, deq_valid}, {127'b0, ev});
    if (ev) begin
      check("deq_pc", {96'b0, deq_pc}, {96'b0, epc});
      check("deq_data", deq_data, mk_data(epc));
    end
    fire = ev && rdy && !stl;
    acc  = wen && !fl && ((sb_pc.size() < DEPTH) || fire);
    if (!rst_n) begin
      sb_pc.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      sb_pc.delete();
    end else begin
      if (wen && !acc) m_ovf = 1'b1;
      if (fire && !byp) void'(sb_pc.pop_front());
      if (acc && !(byp && fire)) sb_pc.push_back(pc);
    end
    @(posedge CLK);
    #1;
    check("count_model", {125'b0, count}, DW'(sb_pc.size()));
    check("full_model", {127'b0, is_queue_full}, {127'b0, sb_pc.size() == DEPTH});
    check("overflow_model", {127'b0, overflow}, {127'b0, m_ovf});
  endtask

  function automatic void add(input logic rst_n, input logic wen, input logic [31:0] pc,
                              input logic rdy, input logic stl, input logic fl,
                              input int c, input logic f, input logic o);
    vec_t v;
    v.rst_n = rst_n; v.wen = wen; v.pc = pc; v.rdy = rdy; v.stl = stl; v.fl = fl;
    v.exp_cnt = c; v.exp_full = f; v.exp_ovf = o;
    tv.push_back(v);
  endfunction

  initial begin
    // idle after reset
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // fill, overflow, drain in order
    add(1, 1, 32'h100, 0, 0, 0, 1, 0, 0);
    add(1, 1, 32'h104, 0, 0, 0, 2, 0, 0);
    add(1, 1, 32'h108, 0, 0, 0, 3, 0, 0);
    add(1, 1, 32'h10C, 0, 0, 0, 4, 1, 0);
    add(1, 1, 32'h110, 0, 0, 0, 4, 1, 1);
    add(1, 0, 0, 1, 0, 0, 3, 0, 1);
    add(1, 0, 0, 1, 0, 0, 2, 0, 1);
    add(1, 0, 0, 1, 0, 0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 1);
    // reset clears sticky overflow
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // push while full with simultaneous pop
    add(1, 1, 32'h100, 0, 0, 0, 1, 0, 0);
    add(1, 1, 32'h104, 0, 0, 0, 2, 0, 0);
    add(1, 1, 32'h108, 0, 0, 0, 3, 0, 0);
    add(1, 1, 32'h10C, 0, 0, 0, 4, 1, 0);
    add(1, 1, 32'h200, 1, 0, 0, 4, 1, 0);
    add(1, 0, 0, 1, 0, 0, 3, 0, 0);
    // stall blocks dequeue, enqueue still accepted
    add(1, 1, 32'h204, 1, 1, 0, 4, 1, 0);
    add(1, 0, 0, 1, 1, 0, 4, 1, 0);
    add(1, 0, 0, 1, 1, 0, 4, 1, 0);
    add(1, 0, 0, 1, 0, 0, 3, 0, 0);
    add(1, 0, 0, 1, 0, 0, 2, 0, 0);
    // flush discards entries and a concurrent push/pop
    add(1, 1, 32'h208, 1, 0, 1, 0, 0, 0);
    add(1, 1, 32'h300, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    // reset mid-operation dominates enqueue and dequeue
    add(1, 1, 32'h400, 0, 0, 0, 1, 0, 0);
    add(1, 1, 32'h404, 0, 0, 0, 2, 0, 0);
    add(0, 1, 32'h408, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);

    nRST = 1'b0; queue_wen = 1'b0; enq_pc = '0; enq_data = '0;
    deq_ready = 1'b0; stall_queue = 1'b0; flush_queue = 1'b0;
    m_ovf = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_count", {125'b0, count}, '0);
    check("reset_valid", {127'b0, deq_valid}, '0);
    check("reset_full", {127'b0, is_queue_full}, '0);
    check("reset_overflow", {127'b0, overflow}, '0);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst_n, tv[i].wen, tv[i].pc, tv[i].rdy, tv[i].stl, tv[i].fl);
      check($sformatf("vec%0d_count", i), {125'b0, count}, DW'(tv[i].exp_cnt));
      check($sformatf("vec%0d_full", i), {127'b0, is_queue_full}, {127'b0, tv[i].exp_full});
      check($sformatf("vec%0d_overflow", i), {127'b0, overflow}, {127'b0, tv[i].exp_ovf});
    end

    // continuous push/pop of 20 entries wraps the pointers several times
    for (int i = 0; i < 20; i++) step(1, 1, 32'h500 + 32'(4 * i), 1, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 0, 0);
    check("stream_drained", {125'b0, count}, '0);

    // push into empty queue with execute ready
    step(1, 1, 32'h400, 1, 0, 0);
`ifdef INST_QUEUE_BYPASS_EN
    check("bypass_count", {125'b0, count}, '0);
`else
    check("nobypass_count", {125'b0, count}, DW'(1));
    step(1, 0, 0, 1, 0, 0);
`endif

    // randomized traffic, including occasional flush and stall
    for (int i = 0; i < 80; i++)
      step(1, 1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(4 * i), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 15) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
